// File: rtl/execute_stage_mc.sv
// Execute stage: forwarding, single-cycle ALU, branch resolution and E->M register.
// Optional iterative multiply/divide unit is built when MULDIV_EN is defined.
module execute_stage_mc #(
    parameter int XLEN   = 32,
    parameter int REGIDX = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ValidE,
    input  logic              FlushE,
    input  logic [XLEN-1:0]   RD1E,
    input  logic [XLEN-1:0]   RD2E,
    input  logic [XLEN-1:0]   PCE,
    input  logic [XLEN-1:0]   ImmExtE,
    input  logic [XLEN-1:0]   PCPlus4E,
    input  logic [XLEN-1:0]   ResultW,
    input  logic [REGIDX-1:0] Rs1E,
    input  logic [REGIDX-1:0] Rs2E,
    input  logic [REGIDX-1:0] RdE,
    input  logic [1:0]        ForwardAE,
    input  logic [1:0]        ForwardBE,
    input  logic [3:0]        ALUControlE,
    input  logic              ALUSrcE,
    input  logic              RegWriteE,
    input  logic              MemWriteE,
    input  logic              JumpE,
    input  logic              BranchE,
    input  logic [1:0]        ResultSrcE,
    output logic              StallE,
    output logic              PCSrcE,
    output logic [XLEN-1:0]   PCTargetE,
    output logic [XLEN-1:0]   ALUResultM,
    output logic [XLEN-1:0]   WriteDataM,
    output logic [XLEN-1:0]   PCPlus4M,
    output logic [REGIDX-1:0] RdM,
    output logic              ValidM,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic [1:0]        ResultSrcM
);

    function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0] sel,
                                                 input logic [XLEN-1:0] rf,
                                                 input logic [XLEN-1:0] w,
                                                 input logic [XLEN-1:0] m);
        case (sel)
            2'b01:   return w;
            2'b10:   return m;
            default: return rf;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] alu_single(input logic [XLEN-1:0] a,
                                                    input logic [XLEN-1:0] b,
                                                    input logic [3:0] ctrl);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        sa = a;
        sb = b;
        case (ctrl)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0010: return a & b;
            4'b0011: return a | b;
            4'b0100: return a ^ b;
            4'b0101: return {{(XLEN-1){1'b0}}, (sa < sb)};
            4'b0110: return {{(XLEN-1){1'b0}}, (a < b)};
            default: return '0;
        endcase
    endfunction

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] alu_result;
    logic            zero;
    logic            stall;

    // Rs1E/Rs2E are consumed by the hazard unit; they only ride along here.
    logic unused_idx;
    assign unused_idx = ^{Rs1E, Rs2E};

    assign src_a      = fwd_mux(ForwardAE, RD1E, ResultW, ALUResultM);
    assign write_data = fwd_mux(ForwardBE, RD2E, ResultW, ALUResultM);
    assign src_b      = ALUSrcE ? ImmExtE : write_data;

`ifdef MULDIV_EN
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} md_state_t;

    // One shift-add step: {hi,lo} holds partial product over multiplier bits.
    function automatic logic [2*XLEN-1:0] mul_step(input logic [XLEN-1:0] hi,
                                                    input logic [XLEN-1:0] lo,
                                                    input logic [XLEN-1:0] mcand);
        logic [XLEN:0] sum;
        sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
        return {sum, lo[XLEN-1:1]};
    endfunction

    // One restoring step: hi is the partial remainder, lo shifts dividend out / quotient in.
    function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] rem,
                                                    input logic [XLEN-1:0] quo,
                                                    input logic [XLEN-1:0] dvs);
        logic [XLEN:0]   shifted;
        logic [XLEN-1:0] diff;
        shifted = {rem, quo[XLEN-1]};
        diff    = shifted[XLEN-1:0] - dvs;
        if (shifted >= {1'b0, dvs})
            return {diff, quo[XLEN-2:0], 1'b1};
        else
            return {shifted[XLEN-1:0], quo[XLEN-2:0], 1'b0};
    endfunction

    md_state_t       state;
    md_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] md_hi;
    logic [XLEN-1:0] md_lo;
    logic [XLEN-1:0] md_opnd;
    logic [1:0]      md_op;
    logic            md_start;
    logic            md_stall;
    logic            is_md;

    assign is_md = (ALUControlE[3:2] == 2'b10);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (md_start)
                cnt <= '0;
            else if (state == S_BUSY)
                cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        md_stall  = 1'b0;
        md_start  = 1'b0;
        case (state)
            S_IDLE: begin
                if (ValidE && is_md) begin
                    state_nxt = S_BUSY;
                    md_stall  = 1'b1;
                    md_start  = 1'b1;
                end
            end
            S_BUSY: begin
                md_stall = 1'b1;
                if (cnt == CNT_W'(XLEN-1))
                    state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (FlushE) begin
            state_nxt = S_IDLE;
            md_stall  = 1'b0;
            md_start  = 1'b0;
        end
    end

    // Operands are captured at start so forwarding sources may move during the stall.
    always_ff @(posedge clk) begin
        if (md_start) begin
            md_hi   <= '0;
            md_lo   <= ALUControlE[1] ? src_a : src_b;
            md_opnd <= ALUControlE[1] ? src_b : src_a;
            md_op   <= ALUControlE[1:0];
        end else if (state == S_BUSY) begin
            {md_hi, md_lo} <= md_op[1] ? div_step(md_hi, md_lo, md_opnd)
                                       : mul_step(md_hi, md_lo, md_opnd);
        end
    end

    assign stall      = rst_n & md_stall;
    assign alu_result = (state == S_DONE) ? (md_op[0] ? md_hi : md_lo)
                                          : alu_single(src_a, src_b, ALUControlE);
`else
    assign stall      = 1'b0;
    assign alu_result = alu_single(src_a, src_b, ALUControlE);
`endif

    assign StallE    = stall;
    assign zero      = (alu_result == '0);
    assign PCSrcE    = ValidE & ~FlushE & ((zero & BranchE) | JumpE);
    assign PCTargetE = PCE + ImmExtE;

    // E -> M register boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
            RdM        <= '0;
            ValidM     <= 1'b0;
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= '0;
        end else if (stall || FlushE) begin
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
            RdM        <= '0;
            ValidM     <= 1'b0;
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= '0;
        end else begin
            ALUResultM <= alu_result;
            WriteDataM <= write_data;
            PCPlus4M   <= PCPlus4E;
            RdM        <= RdE;
            ValidM     <= ValidE;
            RegWriteM  <= RegWriteE & ValidE;
            MemWriteM  <= MemWriteE & ValidE;
            ResultSrcM <= ResultSrcE;
        end
    end

endmodule

// File: tb/tb_execute_stage_mc.sv
// Randomized bench for execute_stage_mc against a plain-arithmetic reference model.
// Exercises the mul/div paths when MULDIV_EN is defined, the tied-off behaviour otherwise.
module tb_execute_stage_mc;
    localparam int XLEN   = 32;
    localparam int REGIDX = 5;
`ifdef MULDIV_EN
    localparam bit MD_ON = 1'b1;
`else
    localparam bit MD_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic ValidE, FlushE, ALUSrcE, RegWriteE, MemWriteE, JumpE, BranchE;
    logic [XLEN-1:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E, ResultW;
    logic [REGIDX-1:0] Rs1E, Rs2E, RdE;
    logic [1:0] ForwardAE, ForwardBE, ResultSrcE;
    logic [3:0] ALUControlE;
    logic StallE, PCSrcE;
    logic [XLEN-1:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
    logic [REGIDX-1:0] RdM;
    logic ValidM, RegWriteM, MemWriteM;
    logic [1:0] ResultSrcM;

    int tests_run = 0;
    int tests_failed = 0;
    logic [XLEN-1:0] exp_alu_m = '0;

    execute_stage_mc #(.XLEN(XLEN), .REGIDX(REGIDX)) dut (
        .clk(clk), .rst_n(rst_n), .ValidE(ValidE), .FlushE(FlushE),
        .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E),
        .ResultW(ResultW), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ALUControlE(ALUControlE),
        .ALUSrcE(ALUSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ResultSrcE(ResultSrcE),
        .StallE(StallE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
        .RdM(RdM), .ValidM(ValidM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [XLEN-1:0] ref_alu(input logic [3:0] ctrl,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] p;
        p = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
        case (ctrl)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ($signed(a) < $signed(b)) ? 1 : 0;
            4'd6: return (a < b) ? 1 : 0;
            4'd8: return MD_ON ? p[XLEN-1:0] : '0;
            4'd9: return MD_ON ? p[2*XLEN-1:XLEN] : '0;
            4'd10: return !MD_ON ? '0 : (b == 0) ? '1 : a / b;
            4'd11: return !MD_ON ? '0 : (b == 0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] ref_fwd(input logic [1:0] sel, input logic [XLEN-1:0] rf);
        if (sel == 2'b01) return ResultW;
        if (sel == 2'b10) return exp_alu_m;
        return rf;
    endfunction

    function automatic logic [105:0] m_vec();
        return {ALUResultM, WriteDataM, PCPlus4M, RdM, ValidM, RegWriteM, MemWriteM, ResultSrcM};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ValidE = 0; FlushE = 0; ALUSrcE = 0; RegWriteE = 0; MemWriteE = 0;
        JumpE = 0; BranchE = 0; RD1E = 0; RD2E = 0; PCE = 0; ImmExtE = 0;
        PCPlus4E = 0; ResultW = 0; Rs1E = 0; Rs2E = 0; RdE = 0;
        ForwardAE = 0; ForwardBE = 0; ResultSrcE = 0; ALUControlE = 0;
    endtask

    task automatic present(input logic [3:0] ctrl, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        idle_inputs();
        ValidE = 1; RegWriteE = 1; ALUControlE = ctrl; RD1E = a; RD2E = b;
        RdE = 5'($urandom_range(1, 31));
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (m_vec() !== '0 || StallE !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_init: m=%h stall=%b, required all zero", m_vec(), StallE);
        end
        rst_n = 1;
        present(4'd0, 32'd10, 32'd20);
        tick();
        tests_run++;
        if (ALUResultM !== 32'd30) begin
            tests_failed++;
            $display("FAIL pre_reset_add: got %h required %h", ALUResultM, 32'd30);
        end
        #2 rst_n = 0;
        #1;
        tests_run++;
        if (m_vec() !== '0 || StallE !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: m=%h stall=%b, required all zero", m_vec(), StallE);
        end
        rst_n = 1;
`ifdef MULDIV_EN
        present(4'd8, 32'd123, 32'd456);
        repeat (5) tick();
        tests_run++;
        if (StallE !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_before_reset: stall got %b required 1", StallE);
        end
        #2 rst_n = 0;
        #1;
        tests_run++;
        if (m_vec() !== '0 || StallE !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_busy: m=%h stall=%b, required all zero", m_vec(), StallE);
        end
        rst_n = 1;
`endif
        present(4'd0, 32'd5, 32'd7);
        #1;
        tests_run++;
        if (StallE !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_stall: got %b required 0", StallE);
        end
        tick();
        tests_run++;
        if (ALUResultM !== 32'd12 || ValidM !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset_add: got %h/%b required 0000000c/1", ALUResultM, ValidM);
        end
        exp_alu_m = 32'd12;
    endtask

    task automatic test_alu_random();
        logic [XLEN-1:0] sa, sb, wd, res, exp_tgt;
        logic [105:0] exp_m;
        logic exp_pcsrc;
        for (int i = 0; i < 60; i++) begin
            idle_inputs();
            ALUControlE = 4'($urandom_range(0, 15));
            while (MD_ON && ALUControlE[3:2] == 2'b10) ALUControlE = 4'($urandom_range(0, 15));
            RD1E = $urandom; RD2E = $urandom; ImmExtE = $urandom; ResultW = $urandom;
            if ($urandom_range(0, 3) == 0) RD2E = RD1E;
            if ($urandom_range(0, 3) == 0) RD1E = 32'($urandom_range(0, 4));
            PCE = $urandom; PCPlus4E = $urandom; RdE = 5'($urandom);
            ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
            ALUSrcE = 1'($urandom); RegWriteE = 1'($urandom); MemWriteE = 1'($urandom);
            JumpE = ($urandom_range(0, 5) == 0); BranchE = 1'($urandom);
            ResultSrcE = 2'($urandom);
            ValidE = ($urandom_range(0, 7) != 0);
            FlushE = ($urandom_range(0, 7) == 0);
            #1;
            sa = ref_fwd(ForwardAE, RD1E);
            wd = ref_fwd(ForwardBE, RD2E);
            sb = ALUSrcE ? ImmExtE : wd;
            res = ref_alu(ALUControlE, sa, sb);
            exp_pcsrc = ValidE & ~FlushE & (((res == 0) & BranchE) | JumpE);
            exp_tgt = PCE + ImmExtE;
            tests_run++;
            if (PCSrcE !== exp_pcsrc || PCTargetE !== exp_tgt || StallE !== 1'b0) begin
                tests_failed++;
                $display("FAIL branch[%0d]: pcsrc=%b tgt=%h stall=%b, required %b %h 0",
                         i, PCSrcE, PCTargetE, StallE, exp_pcsrc, exp_tgt);
            end
            if (FlushE) exp_m = '0;
            else exp_m = {res, wd, PCPlus4E, RdE, ValidE, RegWriteE & ValidE, MemWriteE & ValidE, ResultSrcE};
            tick();
            tests_run++;
            if (m_vec() !== exp_m) begin
                tests_failed++;
                $display("FAIL m_reg[%0d] ctrl=%0d: got %h required %h", i, ALUControlE, m_vec(), exp_m);
            end
            exp_alu_m = exp_m[105:74];
        end
    endtask

    task automatic test_forwarding();
        present(4'd0, 32'd1, 32'd2);
        tick();
        exp_alu_m = 32'd3;
        present(4'd1, 32'hDEAD_BEEF, 32'd4);
        ForwardAE = 2'b10;
        tick();
        tests_run++;
        if (ALUResultM !== 32'hFFFF_FFFF) begin
            tests_failed++;
            $display("FAIL fwd_m_sub: got %h required ffffffff", ALUResultM);
        end
        exp_alu_m = 32'hFFFF_FFFF;
        present(4'd1, 32'h55, 32'h1234);
        ForwardBE = 2'b01; ResultW = 32'h55; BranchE = 1; PCE = 32'h100; ImmExtE = 32'h20;
        #1;
        tests_run++;
        if (PCSrcE !== 1'b1 || PCTargetE !== 32'h120) begin
            tests_failed++;
            $display("FAIL branch_taken: pcsrc=%b tgt=%h required 1 00000120", PCSrcE, PCTargetE);
        end
        FlushE = 1;
        #1;
        tests_run++;
        if (PCSrcE !== 1'b0) begin
            tests_failed++;
            $display("FAIL branch_flushed: pcsrc=%b required 0", PCSrcE);
        end
        tick();
        tests_run++;
        if (m_vec() !== '0) begin
            tests_failed++;
            $display("FAIL flush_bubble: m=%h required 0", m_vec());
        end
        exp_alu_m = '0;
    endtask

`ifdef MULDIV_EN
    task automatic run_md(input logic [3:0] ctrl, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input bit wiggle);
        int stall_cnt;
        bit bad_valid;
        present(ctrl, a, b);
        if (wiggle) begin
            ForwardAE = 2'b01; ResultW = a; RD1E = ~a;
        end
        #1;
        stall_cnt = 0;
        bad_valid = 0;
        while (StallE === 1'b1 && stall_cnt < 100) begin
            stall_cnt++;
            tick();
            if (ValidM !== 1'b0) bad_valid = 1;
            if (wiggle) ResultW = $urandom;
            #1;
        end
        tick();
        tests_run++;
        if (ALUResultM !== exp || ValidM !== 1'b1 || RegWriteM !== 1'b1) begin
            tests_failed++;
            $display("FAIL md_result ctrl=%0d a=%h b=%h: got %h/%b required %h/1",
                     ctrl, a, b, ALUResultM, ValidM, exp);
        end
        tests_run++;
        if (stall_cnt != XLEN + 1 || bad_valid) begin
            tests_failed++;
            $display("FAIL md_stall ctrl=%0d: stall cycles %0d validm_leak=%0d required %0d/0",
                     ctrl, stall_cnt, bad_valid, XLEN + 1);
        end
        exp_alu_m = exp;
    endtask

    task automatic test_muldiv();
        logic [XLEN-1:0] a, b;
        logic [3:0] c;
        run_md(4'd8, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 0);
        run_md(4'd9, 32'hFFFF_FFFF, 32'd2, 32'd1, 0);
        run_md(4'd10, 32'd100, 32'd7, 32'd14, 1);
        run_md(4'd11, 32'd100, 32'd7, 32'd2, 1);
        run_md(4'd10, 32'd9, 32'd0, 32'hFFFF_FFFF, 0);
        run_md(4'd11, 32'd9, 32'd0, 32'd9, 1);
        for (int i = 0; i < 8; i++) begin
            c = 4'(8 + $urandom_range(0, 3));
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom >> $urandom_range(0, 28));
            run_md(c, a, b, ref_alu(c, a, b), 1'($urandom));
        end
    endtask

    task automatic test_flush();
        present(4'd8, 32'd6, 32'd7);
        tick();
        repeat (9) tick();
        FlushE = 1;
        #1;
        tests_run++;
        if (StallE !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_stall: got %b required 0", StallE);
        end
        tick();
        tests_run++;
        if (ValidM !== 1'b0 || m_vec() !== '0) begin
            tests_failed++;
            $display("FAIL flush_m: m=%h required 0", m_vec());
        end
        present(4'd0, 32'd2, 32'd3);
        #1;
        tests_run++;
        if (StallE !== 1'b0) begin
            tests_failed++;
            $display("FAIL after_flush_stall: got %b required 0", StallE);
        end
        tick();
        tests_run++;
        if (ALUResultM !== 32'd5 || ValidM !== 1'b1) begin
            tests_failed++;
            $display("FAIL after_flush_add: got %h/%b required 00000005/1", ALUResultM, ValidM);
        end
        exp_alu_m = 32'd5;
    endtask
`else
    task automatic test_nomuldiv();
        for (int i = 0; i < 8; i++) begin
            if (i == 0) present(4'd8, 32'd3, 32'd4);
            else present(4'(8 + $urandom_range(0, 3)), $urandom, $urandom);
            #1;
            tests_run++;
            if (StallE !== 1'b0) begin
                tests_failed++;
                $display("FAIL nomd_stall[%0d]: got %b required 0", i, StallE);
            end
            tick();
            tests_run++;
            if (ALUResultM !== '0 || ValidM !== 1'b1) begin
                tests_failed++;
                $display("FAIL nomd_result[%0d]: got %h/%b required 0/1", i, ALUResultM, ValidM);
            end
            exp_alu_m = '0;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_forwarding();
        test_alu_random();
`ifdef MULDIV_EN
        test_muldiv();
        test_flush();
`else
        test_nomuldiv();
`endif
        test_alu_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
